counter_sequencer: RTL and testbench

Command-driven controller that sequences the 4-bit mode up-counter (load, count_en, 2-bit mode c, data_in) from a queue of short programs. Commands (load a value, step +3, step +1, hold) are pushed through a valid/ready interface into an internal FIFO and executed back-to-back, each for a programmed number of cycles. The block replaces hand-written stimulus and firmware pulse-toggling, and sits directly between the host/control bus and the counter's control inputs.

---
 rtl/counter_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_counter_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: queues short command programs (STEP3, STEP1, LOAD, HOLD)
// in a small FIFO and plays them back-to-back onto the control inputs of a
// 4-bit mode up-counter. All counter-facing outputs are registered.
module counter_sequencer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_op,
    input  logic [WIDTH-1:0]          cmd_arg,
    output logic                      cmd_ready,
    input  logic                      flush,
    output logic                      load,
    output logic                      count_en,
    output logic [1:0]                c,
    output logic [WIDTH-1:0]          data_in,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_STEP3 = 2'b00,
        OP_STEP1 = 2'b01,
        OP_LOAD  = 2'b10,
        OP_HOLD  = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    typedef struct packed {
        op_e             op;
        logic [WIDTH-1:0] arg;
    } cmd_t;

    // Everything the counter sees, plus the done pulse, travels as one word.
    typedef struct packed {
        logic             load;
        logic             count_en;
        logic [1:0]       c;
        logic [WIDTH-1:0] data_in;
        logic             done;
    } out_t;

    localparam out_t OUT_IDLE = '{1'b0, 1'b0, 2'b11, {WIDTH{1'b0}}, 1'b0};

    // Output word for one EXEC cycle, given the command and the number of
    // active cycles still to run including this one (0 means a no-op cycle).
    function automatic out_t decode(input op_e op, input logic [WIDTH-1:0] arg,
                                    input logic [WIDTH-1:0] rem);
        out_t o;
        o = OUT_IDLE;
        if (op == OP_LOAD) begin
            o.load    = 1'b1;
            o.data_in = arg;
            o.done    = 1'b1;
        end else if (rem == '0) begin
            o.done = 1'b1;
        end else begin
            o.count_en = 1'b1;
            case (op)
                OP_STEP3: o.c = 2'b00;
                OP_STEP1: o.c = 2'b01;
                default:  o.c = 2'b11;
            endcase
            o.done = (rem == WIDTH'(1));
        end
        return o;
    endfunction

    // FIFO storage and bookkeeping
    cmd_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push, pop;
    cmd_t             head;

    // Sequencer state
    state_e           state_q;
    op_e              cur_op_q;
    logic [WIDTH-1:0] cur_arg_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_dec;
    out_t             out_q;

    assign full      = (count_q == FULL_LVL);
    assign empty     = (count_q == '0);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    // A new command is taken when idle, or on the final cycle of the current
    // one (done is high exactly then), so queued commands run with no bubble.
    assign pop       = !flush && !empty && ((state_q == S_IDLE) || out_q.done);
    assign head      = mem_q[rd_ptr_q];
    assign rem_dec   = rem_q - WIDTH'(1);

    // Occupancy next-state: push and pop in the same cycle cancel out.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; flush empties the queue.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO payload storage.
    // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: op_e'(cmd_op), arg: cmd_arg};
    end

    // Command FSM with registered outputs: load a command, count it down, chain the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cur_op_q  <= OP_HOLD;
            cur_arg_q <= '0;
            rem_q     <= '0;
            out_q     <= OUT_IDLE;
        end else if (flush) begin
            state_q <= S_IDLE;
            out_q   <= OUT_IDLE;
        end else if (pop) begin
            state_q   <= S_EXEC;
            cur_op_q  <= head.op;
            cur_arg_q <= head.arg;
            rem_q     <= head.arg;
            out_q     <= decode(head.op, head.arg, head.arg);
        end else if (state_q == S_EXEC) begin
            if (out_q.done) begin
                state_q <= S_IDLE;
                out_q   <= OUT_IDLE;
            end else begin
                rem_q <= rem_dec;
                out_q <= decode(cur_op_q, cur_arg_q, rem_dec);
            end
        end
    end

    assign load     = out_q.load;
    assign count_en = out_q.count_en;
    assign c        = out_q.c;
    assign data_in  = out_q.data_in;
    assign done     = out_q.done;
    assign busy     = (state_q == S_EXEC);
    assign level    = count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed program steps followed by random
// traffic, checked every cycle against a command-expansion reference model
// and an environment model of the 4-bit mode up-counter.
module tb_counter_sequencer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'd0;
    logic       flush = 1'b0;
    logic       cmd_ready, load, count_en, busy, done;
    logic [1:0] c;
    logic [3:0] data_in;
    logic [2:0] level;

    counter_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_ready (cmd_ready),
        .flush     (flush),
        .load      (load),
        .count_en  (count_en),
        .c         (c),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [3:0] arg; } cmd_s;
    typedef struct { logic ld; logic en; logic [1:0] c; logic [3:0] d; logic dn; } cyc_s;

    int         n_tests = 0;
    int         n_fail = 0;
    cmd_s       fifo_m[$];
    cyc_s       pend[$];
    logic [3:0] cnt = 4'd0;
    logic [3:0] done_vals[$];
    logic       last_acc = 1'b0;
    int         exec_cycles = 0;
    int         done_pulses = 0;
    logic       cap_ld, cap_en, cap_dn;
    logic [1:0] cap_c;
    logic [3:0] cap_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cmode(input logic [1:0] op);
        case (op)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // A command becomes the list of output cycles it should produce.
    function automatic void expand(input cmd_s k);
        if (k.op == 2'b10) begin
            pend.push_back('{1'b1, 1'b0, 2'b11, k.arg, 1'b1});
        end else if (k.arg == 4'd0) begin
            pend.push_back('{1'b0, 1'b0, 2'b11, 4'd0, 1'b1});
        end else begin
            for (int i = 0; i < int'(k.arg); i++)
                pend.push_back('{1'b0, 1'b1, cmode(k.op), 4'd0, (i == int'(k.arg) - 1)});
        end
    endfunction

    task automatic capture();
        cap_ld = load; cap_en = count_en; cap_c = c; cap_d = data_in; cap_dn = done;
    endtask

    task automatic compare_outputs();
        cyc_s e;
        logic exp_busy;
        exp_busy = (pend.size() > 0);
        e = exp_busy ? pend[0] : '{1'b0, 1'b0, 2'b11, 4'd0, 1'b0};
        check("load",     32'(load),     32'(e.ld));
        check("count_en", 32'(count_en), 32'(e.en));
        check("c",        32'(c),        32'(e.c));
        check("data_in",  32'(data_in),  32'(e.d));
        check("done",     32'(done),     32'(e.dn));
        check("busy",     32'(busy),     32'(exp_busy));
        check("level",    32'(level),    32'(fifo_m.size()));
        if (busy === 1'b1) exec_cycles++;
        if (done === 1'b1) done_pulses++;
    endtask

    // One clock: check cmd_ready, apply the edge to both models, check outputs at the falling edge.
    task automatic tick();
        logic m_ready;
        cmd_s k;
        #1;
        m_ready = (fifo_m.size() < DEPTH) && !flush;
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        last_acc = cmd_valid && m_ready;
        k = '{cmd_op, cmd_arg};
        @(posedge clk);
        if (cap_ld) cnt = cap_d;
        else if (cap_en && cap_c == 2'b00) cnt = cnt + 4'd3;
        else if (cap_en && cap_c == 2'b01) cnt = cnt + 4'd1;
        if (cap_dn) done_vals.push_back(cnt);
        if (reset && flush) begin
            fifo_m.delete();
            pend.delete();
        end else if (reset) begin
            if (pend.size() > 0) void'(pend.pop_front());
            if (pend.size() == 0 && fifo_m.size() > 0) expand(fifo_m.pop_front());
            if (last_acc) fifo_m.push_back(k);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        flush = 1'b0;
        compare_outputs();
        capture();
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] arg);
        int w;
        w = 0;
        last_acc = 1'b0;
        while (!last_acc && w < 50) begin
            cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
            tick();
            w++;
        end
        check("push_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((pend.size() > 0 || fifo_m.size() > 0) && w < 300) begin
            tick();
            w++;
        end
        check("drain_in_budget", 32'(pend.size() + fifo_m.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_prog[5];
        logic [3:0] cnt0;
        int         done0;
        int         waited;
        exp_prog = '{4'd2, 4'd2, 4'd6, 4'd9, 4'd5};

        // Reset state
        #1;
        capture();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);
        check("level_after_reset", 32'(level), 32'd0);

        // Program run from counter value 0
        done_vals.delete();
        exec_cycles = 0;
        done_pulses = 0;
        push(2'b00, 4'd6);
        push(2'b11, 4'd2);
        push(2'b01, 4'd4);
        push(2'b10, 4'd9);
        push(2'b00, 4'd4);
        drain();
        tick();
        check("prog_exec_cycles", 32'(exec_cycles), 32'd17);
        check("prog_done_pulses", 32'(done_pulses), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("prog_cnt_%0d", i),
                  (i < done_vals.size()) ? 32'(done_vals[i]) : 32'hFFFF_FFFF, 32'(exp_prog[i]));

        // Latency of a LOAD pushed while idle
        push(2'b10, 4'd7);
        check("lat_level_N", 32'(level), 32'd1);
        check("lat_load_N", 32'(load), 32'd0);
        tick();
        check("lat_load_N1", 32'(load), 32'd1);
        check("lat_data_N1", 32'(data_in), 32'd7);
        check("lat_done_N1", 32'(done), 32'd1);
        tick();
        check("lat_cnt_N2", 32'(cnt), 32'd7);

        // FIFO full while a long HOLD executes
        push(2'b11, 4'd15);
        push(2'b01, 4'd1);
        push(2'b00, 4'd1);
        push(2'b11, 4'd1);
        push(2'b01, 4'd2);
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        waited = 0;
        last_acc = 1'b0;
        while (!last_acc && waited < 50) begin
            cmd_op = 2'b10; cmd_arg = 4'd4; cmd_valid = 1'b1;
            tick();
            waited++;
        end
        check("full_fifth_accepted", 32'(last_acc), 32'd1);
        check("full_fifth_held", 32'(waited > 1), 32'd1);
        drain();

        // Zero-argument command followed by STEP1/1
        tick();
        cnt0 = cnt;
        done0 = done_pulses;
        push(2'b00, 4'd0);
        push(2'b01, 4'd1);
        drain();
        check("zero_cnt", 32'(cnt), 32'(cnt0 + 4'd1));
        check("zero_dones", 32'(done_pulses - done0), 32'd2);

        // Flush mid-STEP3/10 with two queued commands and a concurrent push
        tick();
        push(2'b00, 4'd10);
        tick();
        push(2'b01, 4'd2);
        push(2'b11, 4'd3);
        check("flush_pre_level", 32'(level), 32'd2);
        done0 = done_pulses;
        flush = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 4'd5;
        tick();
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_count_en", 32'(count_en), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        repeat (3) tick();
        check("flush_no_done", 32'(done_pulses - done0), 32'd0);
        check("flush_push_dropped", 32'(level), 32'd0);

        // Asynchronous reset in the middle of STEP1/8
        push(2'b01, 4'd8);
        repeat (3) tick();
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_load", 32'(load), 32'd0);
        check("rst_count_en", 32'(count_en), 32'd0);
        check("rst_c", 32'(c), 32'd3);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        fifo_m.delete();
        pend.delete();
        capture();
        tick();
        reset = 1'b1;
        tick();
        push(2'b10, 4'd3);
        drain();
        check("rst_then_load", 32'(cnt), 32'd3);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_arg   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
